t1_channel_demux: RTL and testbench
===================================

# t1_channel_demux

Downstream stage of the 1001 frame-sync detector. Consumes the detector's serial bit stream, its per-frame `frame` pulse and its `flag` lock indication. Once aligned, it splits each 193-bit frame into 24 eight-bit channel samples, MSB first, and emits one byte per channel with a channel index. A flywheel lock FSM tolerates isolated missing frame pulses and drops to hunt after repeated misses or loss of `flag`.

## Interface
- FRAME_BITS, 193, bits per frame: 192 payload bits plus 1 framing slot
- N_CH, 24, channels per frame
- CH_BITS, 8, bits per channel sample
- MISS_MAX, 2, consecutive missing frame pulses that force HUNT (range 1..7)

- clk  in  1  system clock; one serial bit per cycle
- reset  in  1  synchronous, active-high
- in  in  1  serial data bit, same stream the detector sees
- frame  in  1  detector frame pulse; high in cycle T means `in` at T+1 is channel 0 bit 7
- flag  in  1  detector lock flag
- data  out  8  assembled channel sample
- chan  out  5  channel index of `data`, 0..23
- valid  out  1  one-cycle strobe qualifying `data`/`chan`
- sync  out  1  high while the FSM is in SYNC
- frame_err  out  1  one-cycle pulse at a framing slot with no `frame` while in SYNC

## Operation
- The FSM has two states.
- HUNT (reset state):
  - No output bytes.
  - `frame`=1 and `flag`=1 in the same cycle: go to SYNC, bit position `pos` := 0 for the next cycle, miss count := 0.
- SYNC:
  - `pos` runs 0..FRAME_BITS-1 and wraps 192→0.
  - Slots 0..191 are payload. Bit `in` shifts into the assembler MSB first.
  - Slot 192 is the framing slot. `in` is ignored.
  - At slot 192:
    - `frame`=1: clear miss count.
    - `frame`=0: increment miss count and pulse `frame_err`.
    - If the incremented count equals MISS_MAX, go to HUNT.
  - After a miss, the counter keeps running (flywheel); alignment is unchanged.
  - A `frame` pulse at any slot other than 192 is ignored in SYNC. There is no re-alignment in SYNC.
  - `flag`=0 in any SYNC cycle: go to HUNT at the next edge. A byte completing in that cycle is discarded (`valid` stays 0).
- Channel k occupies slots 8k..8k+7. Bit 7 is at slot 8k.
- When slot 8k+7 is sampled, the registered outputs are `data` = assembled byte, `chan` = k, `valid` = 1 on the next cycle.
- `data` and `chan` hold their value between strobes.
- Arithmetic:
  - `pos` is 8 bits wide; compare against FRAME_BITS-1 for wrap.
  - Channel index is `pos[7:3]`, valid only when `pos`<192.
  - Miss count is 3 bits and saturates at MISS_MAX.

## Timing
- Reset values: `data`=0, `chan`=0, `valid`=0, `sync`=0, `frame_err`=0, state HUNT, `pos`=0, miss count 0, assembler cleared.
- Reset mid-frame: everything cleared at the next edge and any partial byte is lost. Relock requires a new `frame`+`flag` cycle.
- Lock latency:
  - `frame`+`flag` in cycle T.
  - `sync`=1 from T+1.
  - Channel 0 bits are sampled at T+1..T+8.
  - First `valid` with `chan`=0 at T+9.
- Byte latency: last bit of a channel sampled in cycle C gives `valid` in C+1.
- Per frame: 24 `valid` strobes, spaced exactly 8 cycles apart. Then a 9-cycle gap from channel 23 to channel 0, because of the framing slot.
- `frame_err`: asserted the cycle after the missed slot 192.
- Drop to HUNT: on the MISS_MAX-th miss, `sync` falls in the same cycle that `frame_err` rises. On `flag` loss, `sync` falls the cycle after `flag`=0.
- `frame` and `flag` both high in HUNT during a cycle when reset is also high: reset wins.

## Structure
- Shared package `t1_pkg`:
  - FRAME_BITS, N_CH, CH_BITS
  - state enum {HUNT, SYNC}
  - The same package is also used by the detector and the upstream framer.
- One sub-module, `t1_byte_assembler`: an 8-bit MSB-first shift register with a load-complete strobe, driven by a shift-enable and a clear.
- The top level holds the FSM, the position counter and the miss counter.

## Test plan
- Lock and unpack: after reset, send `frame`=`flag`=1 with payload where channel k equals k+0xA0.
  - Expect 24 strobes, `chan` 0..23, `data` 0xA0..0xB7.
  - First strobe 9 cycles after the `frame` pulse.
- Flywheel: withhold one `frame` pulse at slot 192 with MISS_MAX=2.
  - Expect one `frame_err` pulse and `sync` held at 1.
  - Next frame bytes are still correct; the miss count clears on the following pulse.
- Loss by misses: withhold two consecutive frame pulses.
  - Expect `frame_err` twice and `sync`=0 with the second.
  - No `valid` until the next `frame`+`flag`.
- Flag drop: deassert `flag` in the cycle that channel 5's last bit arrives.
  - Expect no `valid` for channel 5 and `sync`=0 the next cycle.
- Spurious pulse: in SYNC, pulse `frame` at slot 50.
  - Expect no realignment and bytes unchanged.
- Reset mid-frame: assert reset at slot 100.
  - Expect all outputs 0 next cycle.
  - Relock on the next valid pulse with `chan` restarting at 0.

Source files
------------

// File: rtl/t1_pkg.sv
// Shared T1 framing package. The 1001 frame-sync detector, the upstream
// framer and the channel demux all import it.
//   FRAME_BITS : bits per T1 frame (192 payload + 1 framing slot)
//   N_CH       : channels per frame
//   CH_BITS    : bits per channel sample
//   state_e    : lock state shared by the sync-tracking blocks
package t1_pkg;
  localparam int FRAME_BITS = 193;
  localparam int N_CH       = 24;
  localparam int CH_BITS    = 8;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;
endpackage

// File: rtl/t1_byte_assembler.sv
// MSB-first serial-to-parallel assembler for one channel sample.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : drop any partial byte
//   shift_i    : shift bit_i in this cycle
//   bit_i      : serial data bit
//   last_i     : this shift is the final (LSB) bit of the sample
//   byte_o     : assembled sample including the current bit_i
//   done_o     : byte_o is complete this cycle
module t1_byte_assembler
  import t1_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic               last_i,
  output logic [CH_BITS-1:0] byte_o,
  output logic               done_o
);
  logic [CH_BITS-1:0] sr_q, sr_d;

  // The LSB arrives in the completing cycle, so it is merged combinationally
  // and the top level can register the full byte on that same edge.
  assign byte_o = {sr_q[CH_BITS-2:0], bit_i};
  assign done_o = shift_i & last_i;

  always_comb begin
    sr_d = sr_q;
    if (clr_i)        sr_d = '0;
    else if (shift_i) sr_d = byte_o;
  end

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end
endmodule

// File: rtl/t1_channel_demux.sv
// T1 channel demultiplexer, downstream of the 1001 frame-sync detector.
// Once locked it splits each 193-bit frame into 24 eight-bit samples,
// MSB first, and strobes each out with its channel index. A flywheel
// tolerates up to MISS_MAX-1 consecutive missing frame pulses.
//   clk, reset : clock (one serial bit per cycle), synchronous active-high reset
//   in         : serial data bit
//   frame      : detector frame pulse; next cycle carries channel 0 bit 7
//   flag       : detector lock flag
//   data, chan : last assembled sample and its channel (held between strobes)
//   valid      : one-cycle strobe qualifying data/chan
//   sync       : FSM is in SYNC
//   frame_err  : one-cycle pulse after a framing slot with no frame pulse
module t1_channel_demux
  import t1_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       frame,
  input  logic       flag,
  output logic [7:0] data,
  output logic [4:0] chan,
  output logic       valid,
  output logic       sync,
  output logic       frame_err
);
  localparam logic [7:0] LAST_SLOT    = 8'(FRAME_BITS - 1);
  localparam logic [7:0] PAYLOAD_BITS = 8'(N_CH * CH_BITS);
  localparam logic [2:0] MISS_LIM     = 3'(MISS_MAX);

  state_e       state_q;
  logic [7:0]   pos_q, pos_d;
  logic [2:0]   miss_q, miss_inc;
  logic [7:0]   data_q;
  logic [4:0]   chan_q;
  logic         valid_q, ferr_q;

  logic         in_sync, shift_en, fr_slot, lock_req;
  logic [7:0]   asm_byte;
  logic         asm_done;

  assign in_sync  = (state_q == SYNC);
  assign shift_en = in_sync && (pos_q < PAYLOAD_BITS);
  assign fr_slot  = in_sync && (pos_q == LAST_SLOT);
  assign lock_req = !in_sync && frame && flag;
  assign pos_d    = (pos_q == LAST_SLOT) ? 8'd0 : 8'(pos_q + 8'd1);
  assign miss_inc = 3'(miss_q + 3'd1);

  t1_byte_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (lock_req),
    .shift_i (shift_en),
    .bit_i   (in),
    .last_i  (pos_q[2:0] == 3'd7),
    .byte_o  (asm_byte),
    .done_o  (asm_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      pos_q   <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        HUNT: begin
          if (frame && flag) begin
            state_q <= SYNC;
            pos_q   <= '0;
            miss_q  <= '0;
          end
        end
        SYNC: begin
          // Flywheel: the slot counter free-runs; frame is only looked at
          // in the framing slot, so stray pulses never realign.
          pos_q <= pos_d;
          if (asm_done && flag) begin
            data_q  <= asm_byte;
            chan_q  <= pos_q[7:3];
            valid_q <= 1'b1;
          end
          if (fr_slot) begin
            if (frame) begin
              miss_q <= '0;
            end else begin
              ferr_q <= 1'b1;
              miss_q <= miss_inc;  // never exceeds MISS_LIM: we leave SYNC there
              if (miss_inc == MISS_LIM) state_q <= HUNT;
            end
          end
          if (!flag) state_q <= HUNT;
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign data      = data_q;
  assign chan      = chan_q;
  assign valid     = valid_q;
  assign sync      = (state_q == SYNC);
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_t1_channel_demux.sv
module tb_t1_channel_demux;
  localparam int MISS_MAX = 2;

  logic       clk = 1'b0;
  logic       reset, in, frame, flag;
  logic [7:0] data;
  logic [4:0] chan;
  logic       valid, sync, frame_err;

  t1_channel_demux #(.MISS_MAX(MISS_MAX)) dut (
    .clk(clk), .reset(reset), .in(in), .frame(frame), .flag(flag),
    .data(data), .chan(chan), .valid(valid), .sync(sync), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // Behavioural model: lock state plus the absolute cycle of the lock pulse;
  // slot = (cycle - lock cycle - 1) mod 193, bytes read from the bit history.
  bit         m_locked = 0;
  int         lock_t = 0, m_miss = 0;
  logic       hist[$];
  logic [7:0] e_data = 0;
  logic [4:0] e_chan = 0;
  logic       e_valid = 0, e_sync = 0, e_ferr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model(input logic i, input logic f, input logic fl, input logic r);
    int p;
    logic [7:0] b;
    hist.push_back(i);
    e_valid = 0;
    e_ferr  = 0;
    if (r) begin
      m_locked = 0; m_miss = 0; e_data = 0; e_chan = 0;
    end else if (!m_locked) begin
      if (f && fl) begin m_locked = 1; lock_t = cyc; m_miss = 0; end
    end else begin
      p = (cyc - lock_t - 1) % 193;
      if (p < 192 && (p % 8) == 7 && fl) begin
        for (int j = 0; j < 8; j++) b[7-j] = hist[hist.size() - 8 + j];
        e_valid = 1; e_data = b; e_chan = 5'(p / 8);
      end
      if (p == 192 && !f) begin
        m_miss++;
        e_ferr = 1;
        if (m_miss == MISS_MAX) m_locked = 0;
      end else if (p == 192) begin
        m_miss = 0;
      end
      if (!fl) m_locked = 0;
    end
    e_sync = m_locked;
  endtask

  task automatic step(input logic i, input logic f, input logic fl, input logic r);
    in = i; frame = f; flag = fl; reset = r;
    model(i, f, fl, r);
    @(posedge clk); #1;
    chk("valid", valid, e_valid);
    chk("sync", sync, e_sync);
    chk("frame_err", frame_err, e_ferr);
    chk("data", data, e_data);
    chk("chan", chan, e_chan);
    cyc++;
  endtask

  // Sends slots 0..192 of one frame; channel k carries base+k.
  task automatic send_frame(input logic [7:0] base, input logic pulse, input int spur,
                            input int drop, input int rst,
                            output int nv, output int first, output logic [7:0] fd,
                            output logic [4:0] fc, output logic [7:0] ld, output int fe);
    logic [7:0] chv;
    logic       bi;
    nv = 0; first = -1; fd = 0; fc = 0; ld = 0; fe = 0;
    for (int s = 0; s < 193; s++) begin
      chv = 8'(base + 8'(s / 8));
      bi  = (s < 192) ? chv[7 - (s % 8)] : 1'b0;
      step(bi, (s == 192) ? pulse : (s == spur), (s != drop), (s == rst));
      if (valid) begin
        if (first < 0) begin first = s; fd = data; fc = chan; end
        nv++;
        ld = data;
      end
      if (frame_err) fe++;
    end
  endtask

  int nv, first, fe;
  logic [7:0] fd, ld;
  logic [4:0] fc;

  initial begin
    // Reset with frame+flag high: reset must win.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_sync", sync, 1'b0);
    chk("reset_data", data, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Lock and unpack.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("lock_sync", sync, 1'b1);
    send_frame(8'hA0, 1'b1, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("f1_nvalid", nv, 24);
    chk("f1_first_slot", first, 7);   // T+9 after the frame pulse
    chk("f1_first_data", fd, 8'hA0);
    chk("f1_first_chan", fc, 5'd0);
    chk("f1_last_data", ld, 8'hB7);
    chk("f1_ferr", fe, 0);

    // Flywheel: one missing pulse.
    send_frame(8'h3C, 1'b0, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("f2_ferr", fe, 1);
    chk("f2_sync_held", sync, 1'b1);
    send_frame(8'h51, 1'b1, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("f3_nvalid", nv, 24);
    chk("f3_first_data", fd, 8'h51);
    chk("f3_last_data", ld, 8'h68);

    // Two consecutive misses (the earlier one was cleared, so this needs two).
    send_frame(8'h10, 1'b0, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("f4_sync_held", sync, 1'b1);
    send_frame(8'hE8, 1'b0, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("f5_ferr", fe, 1);
    chk("f5_sync_drop", sync, 1'b0);
    chk("f5_ferr_now", frame_err, 1'b1);
    // frame without flag must not relock.
    for (int k = 0; k < 10; k++) step(k[0], k[1], 1'b0, 1'b0);
    chk("nolock_sync", sync, 1'b0);

    // Relock, spurious pulse at slot 50.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 50, -1, -1, nv, first, fd, fc, ld, fe);
    chk("spur_nvalid", nv, 24);
    chk("spur_last_data", ld, 8'h8E);

    // Flag drop on channel 5's last bit (slot 47).
    send_frame(8'hC0, 1'b0, -1, 47, -1, nv, first, fd, fc, ld, fe);
    chk("drop_nvalid", nv, 5);
    chk("drop_last_data", ld, 8'hC4);
    chk("drop_sync", sync, 1'b0);

    // Reset at slot 100.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, -1, -1, 100, nv, first, fd, fc, ld, fe);
    chk("rst_nvalid", nv, 12);
    chk("rst_data", data, 8'h00);
    chk("rst_chan", chan, 5'd0);
    chk("rst_sync", sync, 1'b0);

    // Relock after reset: chan restarts at 0.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, -1, -1, -1, nv, first, fd, fc, ld, fe);
    chk("relock_nvalid", nv, 24);
    chk("relock_first_chan", fc, 5'd0);
    chk("relock_first_data", fd, 8'h01);
    chk("relock_last_data", ld, 8'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
